// File: rtl/inst_line_fetcher_if.sv
// AXI-4 read address/data channels between the fetch buffer (master) and instruction memory (slave).
interface inst_line_fetcher_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_line_fetcher.sv
// Single-line instruction fetch buffer: returns a hit one cycle after the request,
// otherwise refills the whole line with one INCR burst and then returns the word.
module inst_line_fetcher #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int LINE_WORDS = 64,
  parameter int AXI_ID     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [12:0] fetch_pc,
  input  logic        flush,
  output logic        fetch_valid,
  output logic [15:0] fetch_inst,
  output logic        busy,
  output logic        err,
  inst_line_fetcher_if.master axi
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int TW = 12 - OW;

  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RESP} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] buffer [LINE_WORDS];
  logic [12:1]           pc_reg;
  logic [TW-1:0]         tag_reg;
  logic                  line_valid_reg;
  logic                  fill_ok_reg;
  logic                  flush_seen_reg;
  logic                  err_reg;
  logic [OW-1:0]         cnt_reg;
  logic [ADDR_WIDTH-1:0] araddr_reg;
  logic [DATA_WIDTH-1:0] inst_reg;

  logic [TW-1:0] req_tag;
  logic [OW-1:0] req_off;
  logic [OW-1:0] pc_off;
  logic [12:0]   req_base;
  logic          hit, accept, ar_fire, beat, last_beat, fill_ok_now, flush_seen_now;
  logic          arvalid_c, rready_c;
  logic          unused_bits;

  assign req_tag        = fetch_pc[12:OW+1];
  assign req_off        = fetch_pc[OW:1];
  assign pc_off         = pc_reg[OW:1];
  assign req_base       = {req_tag, {(OW+1){1'b0}}};
  assign hit            = line_valid_reg && (tag_reg == req_tag) && !flush;
  assign accept         = (state_reg == ST_IDLE) && fetch_req;
  assign ar_fire        = (state_reg == ST_AR) && axi.arready;
  assign beat           = (state_reg == ST_R) && axi.rvalid;
  assign last_beat      = beat && (&cnt_reg);
  assign fill_ok_now    = fill_ok_reg && (axi.rresp == 2'b00);
  assign flush_seen_now = flush_seen_reg || flush;
  assign unused_bits    = ^{axi.rid, fetch_pc[0]};

  assign axi.arid    = ID_WIDTH'(AXI_ID);
  assign axi.araddr  = araddr_reg;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'b001;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_c;
  assign axi.rready  = rready_c;
  assign fetch_inst  = inst_reg;
  assign err         = err_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    fetch_valid = 1'b0;
    busy        = 1'b1;
    arvalid_c   = 1'b0;
    rready_c    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (fetch_req) state_next = hit ? ST_RESP : ST_AR;
      end
      ST_AR: begin
        arvalid_c = 1'b1;
        if (axi.arready) state_next = ST_R;
      end
      ST_R: begin
        rready_c = 1'b1;
        if (last_beat) state_next = ST_RESP;
      end
      ST_RESP: begin
        fetch_valid = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= '0;
      tag_reg        <= '0;
      line_valid_reg <= 1'b0;
      fill_ok_reg    <= 1'b0;
      flush_seen_reg <= 1'b0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
      araddr_reg     <= '0;
    end else begin
      if (accept) begin
        pc_reg     <= fetch_pc[12:1];
        araddr_reg <= ADDR_WIDTH'(req_base);
      end
      // A flush seen while the line is in flight keeps the refilled line invalid.
      if (accept)
        flush_seen_reg <= 1'b0;
      else if ((state_reg == ST_AR || state_reg == ST_R) && flush)
        flush_seen_reg <= 1'b1;
      if (ar_fire) begin
        cnt_reg     <= '0;
        fill_ok_reg <= 1'b1;
      end
      if (beat) begin
        cnt_reg     <= cnt_reg + OW'(1);
        fill_ok_reg <= fill_ok_now;
        if (axi.rlast != (&cnt_reg)) err_reg <= 1'b1;
      end
      if (last_beat) begin
        tag_reg        <= pc_reg[12:OW+1];
        line_valid_reg <= fill_ok_now && !flush_seen_now;
      end else if (flush) begin
        line_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) buffer[cnt_reg] <= axi.rdata;
  end

  // Hits read the line; on a refill the requested beat is captured as it streams past.
  always_ff @(posedge clk) begin
    if (rst)
      inst_reg <= '0;
    else if (accept)
      inst_reg <= buffer[req_off];
    else if (beat && (cnt_reg == pc_off))
      inst_reg <= axi.rdata;
  end
endmodule

// File: tb/tb_inst_line_fetcher.sv
// Directed bench for inst_line_fetcher: vector table of fetches plus hand-written corner sequences.
module tb_inst_line_fetcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [12:0] fetch_pc = '0;
  logic        flush = 1'b0;
  logic        fetch_valid;
  logic [15:0] fetch_inst;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  inst_line_fetcher_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(16)) axi ();

  inst_line_fetcher #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .LINE_WORDS(64), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .busy(busy), .err(err), .axi(axi)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory image: each 16-bit word is its own byte address tagged with 3'b101.
  function automatic logic [15:0] mem_word(input logic [12:0] a);
    return {3'b101, a};
  endfunction

  typedef struct {
    logic [12:0] pc;
    bit          fl;
    int          ar_delay;
    bit          gap;
    int          err_beat;
    int          last_beat;
    int          flush_beat;
    bit          exp_hit;
    logic [15:0] exp_inst;
    logic [31:0] exp_araddr;
    bit          exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  bit          r_valid, r_ar_seen, r_unstable, r_ardrop, r_rdrop, r_lat_ok, r_rst_done;
  bit          r_hdr_ok, r_busy_at_valid, r_idle_after;
  logic [15:0] r_inst;
  logic [31:0] r_araddr;
  int          r_beats;

  task automatic run_fetch(input logic [12:0] pc, input bit fl, input int ar_delay, input bit gap,
                           input int err_beat, input int last_beat, input int flush_beat,
                           input int rst_beat);
    logic [12:0] base;
    int          ar_wait, cyc, last_cyc;
    bit          ar_done, in_r, tog;
    base = pc & 13'h1F80;
    r_valid = 0; r_inst = '0; r_ar_seen = 0; r_araddr = '0; r_beats = 0; r_unstable = 0;
    r_ardrop = 0; r_rdrop = 0; r_lat_ok = 0; r_rst_done = 0; r_hdr_ok = 1;
    r_busy_at_valid = 0; r_idle_after = 0;
    ar_wait = 0; last_cyc = -10; ar_done = 0; in_r = 0; tog = 0;
    fetch_req = 1'b1; fetch_pc = pc; flush = fl;
    @(negedge clk);
    fetch_req = 1'b0; flush = 1'b0; fetch_pc = ~pc;
    cyc = 1;
    while (cyc < 1000) begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; flush = 1'b0;
      if (fetch_valid) begin
        r_valid = 1; r_inst = fetch_inst; r_busy_at_valid = busy;
        r_lat_ok = (last_cyc < 0) ? (cyc == 1) : (cyc == last_cyc + 1);
        break;
      end
      if (axi.arvalid) begin
        if (!r_ar_seen) begin
          r_ar_seen = 1; r_araddr = axi.araddr;
          if (axi.arlen !== 8'd63 || axi.arsize !== 3'b001 || axi.arburst !== 2'b01 ||
              axi.arid !== 4'd0) r_hdr_ok = 0;
        end else if (axi.araddr !== r_araddr) begin
          r_unstable = 1;
        end
        if (ar_wait >= ar_delay) begin axi.arready = 1'b1; ar_done = 1; end
        else ar_wait++;
      end else if (r_ar_seen && !ar_done) begin
        r_ardrop = 1;
      end
      if (axi.rready) begin
        in_r = 1;
        if (r_beats == rst_beat) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0; r_rst_done = 1;
          break;
        end
        tog = ~tog;
        if (!gap || tog) begin
          axi.rvalid = 1'b1;
          axi.rdata  = mem_word(base + 13'(2 * r_beats));
          axi.rresp  = (r_beats == err_beat) ? 2'b10 : 2'b00;
          axi.rlast  = (last_beat >= 0) ? (r_beats == last_beat) : (r_beats == 63);
          if (r_beats == flush_beat) flush = 1'b1;
          if (r_beats == 63) last_cyc = cyc;
          r_beats++;
        end
      end else if (in_r && r_beats < 64) begin
        r_rdrop = 1;
      end
      @(negedge clk);
      cyc++;
    end
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; flush = 1'b0;
    if (r_valid) begin
      @(negedge clk);
      r_idle_after = !busy && !fetch_valid;
    end
  endtask

  bit exp_pat [4];

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rid = '0;
    //           pc       fl d  g  errb lastb flb hit inst      araddr      err
    vecs[0]  = '{13'h0084, 0, 0, 0, -1, -1, -1, 0, 16'hA084, 32'h0000_0080, 0};
    vecs[1]  = '{13'h00FE, 0, 0, 0, -1, -1, -1, 1, 16'hA0FE, 32'h0000_0080, 0};
    vecs[2]  = '{13'h1F00, 0, 5, 1, -1, -1, -1, 0, 16'hBF00, 32'h0000_1F00, 0};
    vecs[3]  = '{13'h1F3C, 0, 0, 0, -1, -1, -1, 1, 16'hBF3C, 32'h0000_1F00, 0};
    vecs[4]  = '{13'h1F02, 1, 0, 0, -1, -1, -1, 0, 16'hBF02, 32'h0000_1F00, 0};
    vecs[5]  = '{13'h1F04, 0, 0, 0, -1, -1, -1, 1, 16'hBF04, 32'h0000_1F00, 0};
    vecs[6]  = '{13'h0200, 0, 0, 0, -1, -1,  7, 0, 16'hA200, 32'h0000_0200, 0};
    vecs[7]  = '{13'h0210, 0, 0, 0, -1, -1, -1, 0, 16'hA210, 32'h0000_0200, 0};
    vecs[8]  = '{13'h0212, 0, 0, 0, -1, -1, -1, 1, 16'hA212, 32'h0000_0200, 0};
    vecs[9]  = '{13'h0400, 0, 0, 0, 10, -1, -1, 0, 16'hA400, 32'h0000_0400, 0};
    vecs[10] = '{13'h0402, 0, 0, 0, -1, -1, -1, 0, 16'hA402, 32'h0000_0400, 0};
    vecs[11] = '{13'h0404, 0, 0, 0, -1, -1, -1, 1, 16'hA404, 32'h0000_0400, 0};
    vecs[12] = '{13'h0600, 0, 0, 0, -1, 30, -1, 0, 16'hA600, 32'h0000_0600, 1};
    vecs[13] = '{13'h0000, 0, 2, 1, -1, -1, -1, 0, 16'hA000, 32'h0000_0000, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset fetch_valid", fetch_valid, 0);
    chk("reset fetch_inst", fetch_inst, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset arvalid", axi.arvalid, 0);
    chk("reset rready", axi.rready, 0);
    chk("reset araddr", axi.araddr, 0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      vec_t v;
      v = vecs[i];
      run_fetch(v.pc, v.fl, v.ar_delay, v.gap, v.err_beat, v.last_beat, v.flush_beat, -1);
      chk($sformatf("v%0d returned", i), r_valid, 1);
      chk($sformatf("v%0d inst", i), r_inst, v.exp_inst);
      chk($sformatf("v%0d latency", i), r_lat_ok, 1);
      chk($sformatf("v%0d busy_at_valid", i), r_busy_at_valid, 1);
      chk($sformatf("v%0d ar_issued", i), r_ar_seen, !v.exp_hit);
      if (!v.exp_hit) begin
        chk($sformatf("v%0d araddr", i), r_araddr, v.exp_araddr);
        chk($sformatf("v%0d beats", i), r_beats, 64);
        chk($sformatf("v%0d ar_header", i), r_hdr_ok, 1);
        chk($sformatf("v%0d araddr_stable", i), r_unstable, 0);
        chk($sformatf("v%0d arvalid_held", i), r_ardrop, 0);
        chk($sformatf("v%0d rready_held", i), r_rdrop, 0);
      end
      chk($sformatf("v%0d err", i), err, v.exp_err);
      chk($sformatf("v%0d idle_after", i), r_idle_after, 1);
      $display("vec %0d pc=%h flush=%0d hit=%0d inst=%h beats=%0d err=%0d",
               i, v.pc, v.fl, !r_ar_seen, r_inst, r_beats, err);
    end

    // Request held high on a hit: accepted, ignored in the response cycle, accepted again.
    exp_pat[0] = 1; exp_pat[1] = 0; exp_pat[2] = 1; exp_pat[3] = 0;
    fetch_req = 1'b1; fetch_pc = 13'h0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b valid%0d", k), fetch_valid, exp_pat[k]);
      if (exp_pat[k]) chk($sformatf("b2b inst%0d", k), fetch_inst, 16'hA010);
      $display("b2b cycle %0d fetch_valid=%0d inst=%h", k, fetch_valid, fetch_inst);
    end
    fetch_req = 1'b0;
    @(negedge clk);

    // Reset at beat 20 of a burst, then the same PC must refetch the full line.
    run_fetch(13'h0800, 0, 0, 0, -1, -1, -1, 20);
    chk("rst_mid done", r_rst_done, 1);
    chk("rst_mid beats", r_beats, 20);
    chk("rst_mid arvalid", axi.arvalid, 0);
    chk("rst_mid rready", axi.rready, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid fetch_valid", fetch_valid, 0);
    chk("rst_mid err", err, 0);
    chk("rst_mid fetch_inst", fetch_inst, 0);
    $display("reset mid-burst after %0d beats busy=%0d err=%0d", r_beats, busy, err);
    @(negedge clk);
    run_fetch(13'h0800, 0, 1, 0, -1, -1, -1, -1);
    chk("refetch returned", r_valid, 1);
    chk("refetch ar_issued", r_ar_seen, 1);
    chk("refetch araddr", r_araddr, 32'h0000_0800);
    chk("refetch beats", r_beats, 64);
    chk("refetch inst", r_inst, 16'hA800);
    $display("refetch pc=0800 inst=%h beats=%0d", r_inst, r_beats);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
